// File: rtl/ucpu_fetch.sv
// ucpu_fetch: instruction fetch stage for the ucpu core.
// The PC drives the instruction ROM address directly. The returned word is
// registered into the instruction register for the execute stage. Execute can
// stall the stage, redirect it with jump/call/return, or halt it.
// Optional feature macro: UCPU_FETCH_STACK_EN enables the hardware return
// stack, call/ret and the sticky stk_err flag. When the macro is undefined,
// call behaves as jmp, ret is ignored and stk_err is tied low.

module ucpu_fetch #(
   parameter int         STACK_DEPTH = 4,
   parameter logic [7:0] RESET_PC    = 8'h00
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [7:0]  rom_addr,
   output logic        rom_en,
   input  logic [11:0] rom_data,
   input  logic        stall,
   input  logic        halt,
   input  logic        jmp,
   input  logic        call,
   input  logic        ret,
   input  logic [7:0]  tgt_addr,
   output logic [11:0] ir,
   output logic [7:0]  ir_pc,
   output logic        ir_valid,
   output logic        stk_err
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_REDIR = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic [7:0]  r_pc;
   logic [11:0] r_ir;
   logic [7:0]  r_ir_pc;
   logic        r_ir_valid;
   logic        r_rom_en;

   logic        w_fetch;
   logic        w_redirect;
   logic        w_halt_go;
   logic        w_push;
   logic        w_pop;
   logic [7:0]  w_redir_pc;

   logic        w_ret_req;
   logic [7:0]  w_pop_pc;

`ifdef UCPU_FETCH_STACK_EN
   localparam int SPW  = $clog2(STACK_DEPTH + 1);
   localparam int IDXW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [7:0]      r_stack [STACK_DEPTH];
   logic [SPW-1:0]  r_sp;
   logic            r_stk_err;

   logic            w_full;
   logic            w_empty;
   logic [IDXW-1:0] w_push_idx;
   logic [IDXW-1:0] w_top_idx;

   assign w_full     = (r_sp == SPW'(STACK_DEPTH));
   assign w_empty    = (r_sp == '0);
   assign w_push_idx = IDXW'(r_sp);
   assign w_top_idx  = IDXW'(r_sp - SPW'(1));
   assign w_ret_req  = ret;
   assign w_pop_pc   = w_empty ? RESET_PC : r_stack[w_top_idx];
   assign stk_err    = r_stk_err;

   // Return stack: push the return address on call, pop on ret; faults
   // (push when full, pop when empty) leave the stack untouched and set
   // the sticky error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sp      <= '0;
         r_stk_err <= 1'b0;
         for (int i = 0; i < STACK_DEPTH; i++) begin
            r_stack[i] <= 8'h00;
         end
      end else begin
         if (w_push) begin
            if (w_full) begin
               r_stk_err <= 1'b1;
            end else begin
               r_stack[w_push_idx] <= r_ir_pc + 8'd1;
               r_sp                <= r_sp + SPW'(1);
            end
         end
         if (w_pop) begin
            if (w_empty) begin
               r_stk_err <= 1'b1;
            end else begin
               r_sp <= r_sp - SPW'(1);
            end
         end
      end
   end
`else
   logic w_unused_stack;

   assign w_ret_req      = 1'b0;
   assign w_pop_pc       = RESET_PC;
   assign stk_err        = 1'b0;
   assign w_unused_stack = &{1'b0, ret, w_push, w_pop, (STACK_DEPTH > 0)};
`endif

   // State register for the RUN / REDIR / HALT controller.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and datapath control decode. Halt wins over everything and
   // is honoured even while stalled. Other redirects are only taken when a
   // valid instruction is sitting in ir and execute is not stalling, with
   // priority ret > call > jmp. REDIR always fetches the target.
   always_comb begin
      w_state_next = r_state;
      w_fetch      = 1'b0;
      w_redirect   = 1'b0;
      w_halt_go    = 1'b0;
      w_push       = 1'b0;
      w_pop        = 1'b0;
      w_redir_pc   = tgt_addr;
      case (r_state)
         ST_RUN: begin
            if (halt) begin
               w_halt_go    = 1'b1;
               w_state_next = ST_HALT;
            end else if (!stall) begin
               if (r_ir_valid && w_ret_req) begin
                  w_pop        = 1'b1;
                  w_redirect   = 1'b1;
                  w_redir_pc   = w_pop_pc;
                  w_state_next = ST_REDIR;
               end else if (r_ir_valid && call) begin
                  w_push       = 1'b1;
                  w_redirect   = 1'b1;
                  w_state_next = ST_REDIR;
               end else if (r_ir_valid && jmp) begin
                  w_redirect   = 1'b1;
                  w_state_next = ST_REDIR;
               end else begin
                  w_fetch = 1'b1;
               end
            end
         end
         ST_REDIR: begin
            if (halt) begin
               w_halt_go    = 1'b1;
               w_state_next = ST_HALT;
            end else begin
               w_fetch      = 1'b1;
               w_state_next = ST_RUN;
            end
         end
         ST_HALT: begin
            w_state_next = ST_HALT;
         end
         default: begin
            w_state_next = ST_RUN;
         end
      endcase
   end

   // Fetch datapath: capture the ROM word and advance the PC, load the PC
   // with a redirect target (leaving a one-cycle bubble), or freeze on halt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc       <= RESET_PC;
         r_ir       <= 12'h000;
         r_ir_pc    <= 8'h00;
         r_ir_valid <= 1'b0;
         r_rom_en   <= 1'b1;
      end else begin
         if (w_fetch) begin
            r_ir       <= rom_data;
            r_ir_pc    <= r_pc;
            r_ir_valid <= 1'b1;
            r_pc       <= r_pc + 8'd1;
         end
         if (w_redirect) begin
            r_pc       <= w_redir_pc;
            r_ir_valid <= 1'b0;
         end
         if (w_halt_go) begin
            r_ir_valid <= 1'b0;
            r_rom_en   <= 1'b0;
         end
      end
   end

   assign rom_addr = r_pc;
   assign rom_en   = r_rom_en;
   assign ir       = r_ir;
   assign ir_pc    = r_ir_pc;
   assign ir_valid = r_ir_valid;

endmodule
